// File: rtl/scan_sndr.sv
// Scan link serial transmitter.
// Takes 16-bit words from a valid/ready stream and, after a send-sync pulse,
// shifts FRAME_WORDS words out MSB first. Frame sync is high for every bit of
// a word, then the line idles for GAP_BITS bit periods.
// Optional feature macro: SNDR_PARITY_EN appends an odd-parity bit to each
// word, sent with frame sync still high.
module scan_sndr #(
  parameter int CLK_DIV     = 4,
  parameter int GAP_BITS    = 2,
  parameter int FRAME_WORDS = 4096
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_send_sync,
  input  logic [15:0] i_st_data,
  input  logic        i_st_vld,
  output logic        o_st_rdy,
  output logic        o_snd_clk,
  output logic        o_snd_data,
  output logic        o_snd_fs,
  output logic        o_busy,
  output logic        o_frame_done
);

`ifdef SNDR_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int CW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int GCW = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ARM,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             fs_q, fs_d;
  logic             data_q, data_d;
  logic [NB-1:0]    sh_q, sh_d;
  logic             bnd;
  logic             st_rdy;
  logic             frame_done;
  logic [WCW-1:0]   wc_inc;

  // Word as it goes on the line: data bits, plus odd parity when enabled.
  function automatic logic [NB-1:0] line_word(input logic [15:0] w);
`ifdef SNDR_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  // A bit boundary is the cycle whose edge wraps the divider back to 0.
  assign bnd    = (cnt_q == CW'(CLK_DIV - 1));
  assign wc_inc = word_cnt_q + 1'b1;

  // Divider, frame sequencing and line next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bnd ? '0 : cnt_q + 1'b1;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    fs_d       = fs_q;
    data_d     = data_q;
    sh_d       = sh_q;
    st_rdy     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_send_sync) begin
          state_d    = S_FETCH;
          word_cnt_d = '0;
        end
      end
      S_FETCH: begin
        st_rdy = 1'b1;
        if (i_st_vld) begin
          sh_d    = line_word(i_st_data);
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bnd) begin
          fs_d      = 1'b1;
          data_d    = sh_q[NB-1];
          sh_d      = {sh_q[NB-2:0], 1'b0};
          bit_cnt_d = 5'(NB - 1);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bnd) begin
          if (bit_cnt_q == 5'd0) begin
            fs_d      = 1'b0;
            data_d    = 1'b0;
            gap_cnt_d = GCW'(GAP_BITS - 1);
            state_d   = S_GAP;
          end else begin
            data_d    = sh_q[NB-1];
            sh_d      = {sh_q[NB-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        // Leaving on the boundary where the count reaches zero lets the
        // FETCH/ARM bit period overlap the last gap period, so back-to-back
        // words see exactly GAP_BITS idle periods.
        if (bnd) begin
          if (gap_cnt_q <= GCW'(1)) begin
            word_cnt_d = wc_inc;
            if (wc_inc == WCW'(FRAME_WORDS)) begin
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and line registers; reset drops the line and aborts any frame.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      fs_q       <= 1'b0;
      data_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      fs_q       <= fs_d;
      data_q     <= data_d;
    end
  end

  // Shift register holds word data only; it is always reloaded before use.
  always_ff @(posedge sys_clk) begin
    sh_q <= sh_d;
  end

  assign o_snd_clk    = (cnt_q >= CW'(CLK_DIV / 2));
  assign o_snd_data   = data_q;
  assign o_snd_fs     = fs_q;
  assign o_st_rdy     = st_rdy;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = frame_done;

endmodule

// File: tb/tb_scan_sndr.sv
// Bench for scan_sndr: timeline reference model checked every cycle, a line
// receiver that rebuilds words, and literal expectations for the plan cases.
`timescale 1ns/1ps
module tb_scan_sndr;

  localparam int CD = 4;
  localparam int GB = 2;
  localparam int FW = 3;
`ifdef SNDR_PARITY_EN
  localparam int NB = 17;
  localparam int FS_LIT = 68;
  localparam logic [NB-1:0] L0 = 17'h14B87;
  localparam logic [NB-1:0] L1 = 17'h00002;
  localparam logic [NB-1:0] L2 = 17'h1FFFF;
`else
  localparam int NB = 16;
  localparam int FS_LIT = 64;
  localparam logic [NB-1:0] L0 = 16'hA5C3;
  localparam logic [NB-1:0] L1 = 16'h0001;
  localparam logic [NB-1:0] L2 = 16'hFFFF;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_send_sync = 1'b0;
  logic [15:0] i_st_data = 16'h0;
  logic        i_st_vld = 1'b0;
  logic        o_st_rdy, o_snd_clk, o_snd_data, o_snd_fs, o_busy, o_frame_done;

  scan_sndr #(.CLK_DIV(CD), .GAP_BITS(GB), .FRAME_WORDS(FW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .i_send_sync(i_send_sync),
    .i_st_data(i_st_data), .i_st_vld(i_st_vld), .o_st_rdy(o_st_rdy),
    .o_snd_clk(o_snd_clk), .o_snd_data(o_snd_data), .o_snd_fs(o_snd_fs),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word as the receiver must see it, computed by counting ones.
  function automatic logic [NB-1:0] ref_bits(input logic [15:0] w);
`ifdef SNDR_PARITY_EN
    int ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(w[i]);
    return {w, (ones % 2 == 0)};
`else
    return w;
`endif
  endfunction

  // Reference model: a timeline in cycles since the last reset edge.
  int            k = 0;
  bit            known = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_last = 1'b0;
  bit            w_have = 1'b0;
  int            m_ready_from = 0;
  int            m_cnt = 0;
  int            w_s = 0;
  logic [NB-1:0] w_bits = '0;

  // Receiver capture and event counters.
  logic [NB-1:0] rx_q[$];
  int            fs_len_q[$];
  int            gap_q[$];
  logic [NB-1:0] rx_acc = '0;
  int            fs_run = 0;
  int            low_run = 0;
  bit            p_fs = 1'b0;
  bit            p_clk = 1'b0;
  int            acc_cnt = 0;
  int            done_cnt = 0;

  always @(negedge sys_clk) begin
    bit e_clk, e_fs, e_data, e_rdy, e_done;
    e_clk = 0; e_fs = 0; e_data = 0; e_rdy = 0; e_done = 0;
    if (known) begin
      e_clk = ((k % CD) >= CD / 2);
      if (w_have && k >= w_s && k < w_s + NB * CD) begin
        e_fs   = 1'b1;
        e_data = w_bits[NB - 1 - (k - w_s) / CD];
      end
      e_rdy  = m_busy && !m_last && (k >= m_ready_from);
      e_done = m_busy && m_last && (k == m_ready_from - 1);
      chk("snd_clk",    32'(o_snd_clk),    32'(e_clk));
      chk("snd_fs",     32'(o_snd_fs),     32'(e_fs));
      chk("snd_data",   32'(o_snd_data),   32'(e_data));
      chk("st_rdy",     32'(o_st_rdy),     32'(e_rdy));
      chk("busy",       32'(o_busy),       32'(m_busy));
      chk("frame_done", 32'(o_frame_done), 32'(e_done));
    end
    if (!rst_n) begin
      known = 1'b1; k = 0; m_busy = 1'b0; m_last = 1'b0; w_have = 1'b0;
    end else if (known) begin
      if (e_done) m_busy = 1'b0;
      else if (!m_busy && i_send_sync) begin
        m_busy = 1'b1; m_ready_from = k + 1; m_cnt = 0; m_last = 1'b0;
      end
      if (e_rdy && i_st_vld) begin
        w_have = 1'b1;
        w_bits = ref_bits(i_st_data);
        w_s    = ((k + 2 + CD - 1) / CD) * CD;
        m_cnt++;
        m_last = (m_cnt == FW);
        m_ready_from = w_s + NB * CD + ((GB > 1) ? GB - 1 : 1) * CD;
      end
      k++;
    end
    if (o_snd_fs && !p_fs) begin
      gap_q.push_back(low_run);
      rx_acc = '0;
      fs_run = 0;
    end
    if (!o_snd_fs && p_fs) begin
      rx_q.push_back(rx_acc);
      fs_len_q.push_back(fs_run);
      low_run = 0;
    end
    if (o_snd_fs) fs_run++; else low_run++;
    if (o_snd_clk && !p_clk && o_snd_fs) rx_acc = {rx_acc[NB-2:0], o_snd_data};
    if (i_st_vld && o_st_rdy && rst_n) acc_cnt++;
    if (o_frame_done) done_cnt++;
    p_fs  = o_snd_fs;
    p_clk = o_snd_clk;
  end

  // Source driver state.
  logic [15:0] src_q[$];
  int          st_q[$];

  task automatic tick();
    bit hs;
    @(negedge sys_clk);
    hs = i_st_vld && o_st_rdy && rst_n;
    @(posedge sys_clk);
    #1;
    i_send_sync = 1'b0;
    if (hs && src_q.size() > 0) begin
      void'(src_q.pop_front());
      void'(st_q.pop_front());
    end
    if (src_q.size() > 0 && st_q[0] > 0) begin
      st_q[0] = st_q[0] - 1;
      i_st_vld = 1'b0; i_st_data = 16'($urandom);
    end else if (src_q.size() > 0) begin
      i_st_vld = 1'b1; i_st_data = src_q[0];
    end else begin
      i_st_vld = 1'b0; i_st_data = 16'($urandom);
    end
  endtask

  task automatic add_word(input logic [15:0] w, input int stall);
    src_q.push_back(w);
    st_q.push_back(stall);
  endtask

  task automatic start_frame();
    i_send_sync = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int bound, input string name, input bit rnd_sync);
    int n = 0;
    while (o_busy && n < bound) begin
      if (rnd_sync && $urandom_range(0, 19) == 0) i_send_sync = 1'b1;
      tick();
      n++;
    end
    if (o_busy) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles", name, o_busy, bound);
    end
  endtask

  task automatic check_frame(input string name, input int rb, input int ab, input int db,
                             input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] wv[3];
    wv[0] = w0; wv[1] = w1; wv[2] = w2;
    chk({name, "_nwords"}, 32'(rx_q.size() - rb), 32'(FW));
    chk({name, "_accepts"}, 32'(acc_cnt - ab), 32'(FW));
    chk({name, "_dones"}, 32'(done_cnt - db), 32'd1);
    for (int i = 0; i < FW; i++)
      if (rb + i < rx_q.size()) chk({name, "_word"}, 32'(rx_q[rb + i]), 32'(ref_bits(wv[i])));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, ab, db, fb, gb;
    logic [7:0] clk_pat;
    logic [15:0] rw0, rw1, rw2;

    // Reset held 3 cycles.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_rdy",  32'(o_st_rdy),     32'd0);
    chk("rst_fs",   32'(o_snd_fs),     32'd0);
    chk("rst_data", 32'(o_snd_data),   32'd0);
    chk("rst_busy", 32'(o_busy),       32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    rst_n = 1'b1;
    clk_pat = '0;
    for (int i = 0; i < 8; i++) begin
      clk_pat = {clk_pat[6:0], o_snd_clk};
      tick();
    end
    chk("clk_pattern", 32'(clk_pat), 32'h33);

    // Frame with continuous valid.
    rb = rx_q.size(); ab = acc_cnt; db = done_cnt; fb = fs_len_q.size(); gb = gap_q.size();
    add_word(16'hA5C3, 0); add_word(16'h0001, 0); add_word(16'hFFFF, 0);
    start_frame();
    wait_idle(1000, "f1", 1'b0);
    chk("f1_nwords", 32'(rx_q.size() - rb), 32'd3);
    if (rx_q.size() >= rb + 3) begin
      chk("f1_word0", 32'(rx_q[rb]),     32'(L0));
      chk("f1_word1", 32'(rx_q[rb + 1]), 32'(L1));
      chk("f1_word2", 32'(rx_q[rb + 2]), 32'(L2));
    end
    for (int i = 0; i < 3; i++)
      if (fb + i < fs_len_q.size()) chk("f1_fs_len", 32'(fs_len_q[fb + i]), 32'(FS_LIT));
    for (int i = 1; i < 3; i++)
      if (gb + i < gap_q.size()) chk("f1_gap_len", 32'(gap_q[gb + i]), 32'd8);
    chk("f1_accepts", 32'(acc_cnt - ab), 32'd3);
    chk("f1_dones", 32'(done_cnt - db), 32'd1);
    chk("f1_busy_end", 32'(o_busy), 32'd0);

    // Source stall of 100 cycles before word 2.
    repeat (3) tick();
    rb = rx_q.size(); ab = acc_cnt; db = done_cnt;
    add_word(16'h1234, 0); add_word(16'hBEEF, 100); add_word(16'h8001, 0);
    start_frame();
    wait_idle(2000, "stall", 1'b0);
    check_frame("stall", rb, ab, db, 16'h1234, 16'hBEEF, 16'h8001);

    // Send-sync pulsed during word 1.
    repeat (2) tick();
    rb = rx_q.size(); ab = acc_cnt; db = done_cnt;
    add_word(16'h5A5A, 0); add_word(16'h00F0, 0); add_word(16'hC001, 0);
    start_frame();
    repeat (100) tick();
    i_send_sync = 1'b1;
    tick();
    wait_idle(1000, "resync", 1'b0);
    check_frame("resync", rb, ab, db, 16'h5A5A, 16'h00F0, 16'hC001);

    // Reset in the middle of word 1, then a clean frame.
    tick();
    add_word(16'h1111, 0); add_word(16'h2222, 0); add_word(16'h3333, 0);
    start_frame();
    for (int n = 0; n < 500 && !(acc_cnt - ab >= 5 && o_snd_fs); n++) tick();
    if (!o_snd_fs) begin
      checks++; errors++;
      $display("FAIL midrst_timeout: fs never rose for word 1, fs=%0b", o_snd_fs);
    end
    rst_n = 1'b0;
    tick();
    chk("midrst_fs",   32'(o_snd_fs),   32'd0);
    chk("midrst_data", 32'(o_snd_data), 32'd0);
    chk("midrst_busy", 32'(o_busy),     32'd0);
    rst_n = 1'b1;
    src_q.delete(); st_q.delete();
    repeat (3) tick();
    rb = rx_q.size(); ab = acc_cnt; db = done_cnt;
    add_word(16'hA5C3, 0); add_word(16'h0001, 0); add_word(16'hFFFF, 0);
    start_frame();
    wait_idle(1000, "postrst", 1'b0);
    chk("postrst_nwords", 32'(rx_q.size() - rb), 32'd3);
    if (rx_q.size() >= rb + 3) begin
      chk("postrst_word0", 32'(rx_q[rb]),     32'(L0));
      chk("postrst_word1", 32'(rx_q[rb + 1]), 32'(L1));
      chk("postrst_word2", 32'(rx_q[rb + 2]), 32'(L2));
    end
    chk("postrst_dones", 32'(done_cnt - db), 32'd1);

    // Randomized frames: random words, phases, stalls and stray syncs.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 7)) tick();
      rw0 = 16'($urandom); rw1 = 16'($urandom); rw2 = 16'($urandom);
      rb = rx_q.size(); ab = acc_cnt; db = done_cnt;
      add_word(rw0, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0);
      add_word(rw1, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0);
      add_word(rw2, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0);
      start_frame();
      wait_idle(2000, "rand", 1'b1);
      check_frame("rand", rb, ab, db, rw0, rw1, rw2);
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
